// File: rtl/p2p_load_arbiter_if.sv
// Handshake bundle between the two requesters/consumer and p2p_load_arbiter.
// master = requesters + consumer side, slave = arbiter side.
interface p2p_load_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              gnt_a;
  logic              req_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_b;
  logic [DATA_W-1:0] load_data;
  logic              shift_enable;
  logic              byte_valid;
  logic              byte_ack;
  logic              timeout;
  logic              busy;

  modport master (
    output req_a, data_a, req_b, data_b, byte_ack,
    input  gnt_a, gnt_b, load_data, shift_enable, byte_valid, timeout, busy
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, byte_ack,
    output gnt_a, gnt_b, load_data, shift_enable, byte_valid, timeout, busy
  );
endinterface

// File: rtl/p2p_load_arbiter.sv
// Round-robin arbiter that loads one of two requester bytes into a shared holding
// register and offers it downstream. Optional HOLD timeout: define P2P_ARB_TIMEOUT_EN.
module p2p_load_arbiter #(
  parameter int DATA_W    = 8
`ifdef P2P_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = 8
`endif
) (
  input logic                clk,
  input logic                n_rst,
  p2p_load_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sel_b;    // current/last winner; doubles as the fairness pointer
  logic              w_req_any;
  logic              w_pick_b;
  logic              w_timeout;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic [DATA_W-1:0] w_load_data;
  logic              w_shift_enable;
  logic              w_byte_valid;
  logic              w_timeout_out;

  assign w_req_any = bus.req_a | bus.req_b;
  // On a tie the requester that did not win last time gets the slot.
  assign w_pick_b  = bus.req_b & (~bus.req_a | ~r_sel_b);

  // NOTE: state registers use non-blocking assignments and reset asynchronously,
  // so every output decoded from them drops to 0 the moment n_rst falls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_sel_b <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req_any) begin
        r_sel_b <= w_pick_b;
      end
    end
  end

`ifdef P2P_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;

  // Held at zero outside HOLD so it starts cleared on every HOLD entry; saturates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (r_state != ST_HOLD) begin
      r_cnt <= '0;
    end else if (!bus.byte_ack && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_HOLD) && !bus.byte_ack && (r_cnt == '1);
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next         = r_state;
    w_gnt_a        = 1'b0;
    w_gnt_b        = 1'b0;
    w_load_data    = '0;
    w_shift_enable = 1'b0;
    w_byte_valid   = 1'b0;
    w_timeout_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shift_enable = 1'b1;
        w_gnt_a        = ~r_sel_b;
        w_gnt_b        = r_sel_b;
        w_load_data    = r_sel_b ? bus.data_b : bus.data_a;
        w_next         = ST_HOLD;
      end
      ST_HOLD: begin
        w_byte_valid  = 1'b1;
        w_timeout_out = w_timeout;
        if (bus.byte_ack || w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt_a        = w_gnt_a;
  assign bus.gnt_b        = w_gnt_b;
  assign bus.load_data    = w_load_data;
  assign bus.shift_enable = w_shift_enable;
  assign bus.byte_valid   = w_byte_valid;
  assign bus.timeout      = w_timeout_out;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_p2p_load_arbiter.sv
// Bench for p2p_load_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_p2p_load_arbiter;

  localparam int DATA_W    = 8;
  localparam int TB_TW     = 4;
  localparam int TO_CYCLES = 1 << TB_TW;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  p2p_load_arbiter_if #(.DATA_W(DATA_W)) bus ();

  p2p_load_arbiter #(
    .DATA_W(DATA_W)
`ifdef P2P_ARB_TIMEOUT_EN
    , .TIMEOUT_W(TB_TW)
`endif
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a byte transaction is one load cycle followed by numbered hold cycles.
  bit m_load;
  bit m_hold;
  bit m_win_a;
  bit m_last_a;
  int m_hold_n;

  function automatic bit exp_timeout();
`ifdef P2P_ARB_TIMEOUT_EN
    return m_hold && (m_hold_n == TO_CYCLES) && !bus.byte_ack;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_load   <= 1'b0;
      m_hold   <= 1'b0;
      m_win_a  <= 1'b0;
      m_last_a <= 1'b0;
      m_hold_n <= 0;
    end else if (m_hold) begin
      if (bus.byte_ack || exp_timeout()) m_hold <= 1'b0;
      else                               m_hold_n <= m_hold_n + 1;
    end else if (m_load) begin
      m_load   <= 1'b0;
      m_hold   <= 1'b1;
      m_hold_n <= 1;
    end else if (bus.req_a || bus.req_b) begin
      m_win_a  <= bus.req_a && !(bus.req_b && m_last_a);
      m_last_a <= bus.req_a && !(bus.req_b && m_last_a);
      m_load   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cmp_gnt_a",        bus.gnt_a,        m_load && m_win_a);
    check("cmp_gnt_b",        bus.gnt_b,        m_load && !m_win_a);
    check("cmp_shift_enable", bus.shift_enable, m_load);
    check("cmp_load_data",    bus.load_data,
          m_load ? (m_win_a ? bus.data_a : bus.data_b) : '0);
    check("cmp_byte_valid",   bus.byte_valid,   m_hold);
    check("cmp_busy",         bus.busy,         m_load || m_hold);
    check("cmp_timeout",      bus.timeout,      exp_timeout());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Advance until a load cycle is observed; returns cycles taken (bounded).
  task automatic wait_load(output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < 8) begin
      cyc();
      look();
      n++;
      if (bus.shift_enable) got = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    bus.req_a    = 1'b0;
    bus.req_b    = 1'b0;
    bus.data_a   = '0;
    bus.data_b   = '0;
    bus.byte_ack = 1'b0;

    // Reset state
    repeat (2) cyc();
    look();
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_load_data", bus.load_data, 8'h00);
    cyc();
    n_rst = 1'b1;

    // Single requester A
    cyc();
    bus.req_a  = 1'b1;
    bus.data_a = 8'hA5;
    look();
    check("t2_idle_no_gnt", bus.gnt_a, 1'b0);
    cyc();
    look();
    check("t2_gnt_a",     bus.gnt_a,        1'b1);
    check("t2_shift_en",  bus.shift_enable, 1'b1);
    check("t2_load_data", bus.load_data,    8'hA5);
    cyc();
    bus.req_a    = 1'b0;
    bus.byte_ack = 1'b1;
    look();
    check("t2_byte_valid", bus.byte_valid, 1'b1);
    cyc();
    bus.byte_ack = 1'b0;
    look();
    check("t2_back_idle", bus.busy, 1'b0);

    // B requests during A's HOLD; ack after 5 hold cycles
    cyc();
    bus.req_a  = 1'b1;
    bus.data_a = 8'h3C;
    cyc();
    look();
    check("t4_gnt_a", bus.gnt_a, 1'b1);
    cyc();
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b1;
    bus.data_b = 8'hC3;
    repeat (4) cyc();
    cyc();
    bus.byte_ack = 1'b1;
    look();
    check("t4_ack_cycle_no_gnt_b", bus.gnt_b, 1'b0);
    cyc();
    bus.byte_ack = 1'b0;
    look();
    check("t4_idle_no_gnt_b", bus.gnt_b, 1'b0);
    cyc();
    look();
    check("t4_gnt_b_2_after_ack", bus.gnt_b,     1'b1);
    check("t4_load_data_b",       bus.load_data, 8'hC3);
    cyc();
    bus.req_b    = 1'b0;
    bus.byte_ack = 1'b1;
    cyc();
    bus.byte_ack = 1'b0;

    // Reset in the middle of A's HOLD
    bus.req_a  = 1'b1;
    bus.data_a = 8'h5A;
    cyc();
    look();
    check("t1_gnt_a", bus.gnt_a, 1'b1);
    cyc();
    bus.req_a = 1'b0;
    look();
    check("t1_holding", bus.byte_valid, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("t1_async_valid", bus.byte_valid,   1'b0);
    check("t1_async_busy",  bus.busy,         1'b0);
    check("t1_async_shift", bus.shift_enable, 1'b0);
    check("t1_async_gnt",   {bus.gnt_a, bus.gnt_b}, 2'b00);
    cyc();
    cyc();
    bus.req_a    = 1'b1;
    bus.req_b    = 1'b1;
    bus.data_a   = 8'h11;
    bus.data_b   = 8'h22;
    bus.byte_ack = 1'b1;
    cyc();
    n_rst = 1'b1;
    look();
    check("t1_idle_first", {bus.gnt_a, bus.gnt_b}, 2'b00);

    // Continuous ties alternate A,B,A,B with A first after reset
    for (int k = 0; k < 4; k++) begin
      wait_load(got, n);
      check($sformatf("t3_load_%0d_seen", k), got, 1'b1);
      check($sformatf("t3_gnt_a_%0d", k),     bus.gnt_a, (k % 2 == 0));
      check($sformatf("t3_data_%0d", k),      bus.load_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      check($sformatf("t3_spacing_%0d", k),   n, (k == 0) ? 1 : 3);
    end
    cyc();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;

    // byte_ack in IDLE and LOAD is ignored
    cyc();
    look();
    check("t5_idle_ack_no_valid", bus.byte_valid, 1'b0);
    cyc();
    bus.req_a  = 1'b1;
    bus.data_a = 8'h77;
    cyc();
    look();
    check("t5_gnt_a_with_ack", bus.gnt_a, 1'b1);
    cyc();
    bus.req_a    = 1'b0;
    bus.byte_ack = 1'b0;
    cyc();
    look();
    check("t5_hold_needs_fresh_ack", bus.byte_valid, 1'b1);

`ifdef P2P_ARB_TIMEOUT_EN
    // No ack: timeout on the 16th HOLD cycle
    repeat (TO_CYCLES - 2) cyc();
    look();
    check("t6_timeout_pulse", bus.timeout,    1'b1);
    check("t6_valid_at_to",   bus.byte_valid, 1'b1);
    cyc();
    look();
    check("t6_after_to_valid", bus.byte_valid, 1'b0);
    check("t6_after_to_pulse", bus.timeout,    1'b0);
    // Ack on the terminal cycle wins
    cyc();
    bus.req_a = 1'b1;
    cyc();
    cyc();
    bus.req_a = 1'b0;
    repeat (TO_CYCLES - 2) cyc();
    cyc();
    bus.byte_ack = 1'b1;
    look();
    check("t6_ack_beats_timeout", bus.timeout,    1'b0);
    check("t6_ack_cycle_valid",   bus.byte_valid, 1'b1);
    cyc();
    bus.byte_ack = 1'b0;
    look();
    check("t6_ack_released", bus.byte_valid, 1'b0);
`else
    // Without the timeout option HOLD waits indefinitely
    repeat (20) cyc();
    look();
    check("t6_still_holding", bus.byte_valid, 1'b1);
    check("t6_no_timeout",    bus.timeout,    1'b0);
    cyc();
    bus.byte_ack = 1'b1;
    cyc();
    bus.byte_ack = 1'b0;
    look();
    check("t6_released", bus.busy, 1'b0);
`endif

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
